// File: rtl/dma_pkg.sv
// Shared definitions for the DMA transfer engine: state encoding, write-enable
// codes and default widths.
package dma_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int CNT_W_DEF  = 16;
    localparam int DATA_W_DEF = 16;

    // Byte write enables presented on dma_we
    localparam logic [1:0] DMA_WE_READ  = 2'b00;
    localparam logic [1:0] DMA_WE_WRITE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

endpackage

// File: rtl/dma_word_buf.sv
// One-word hand-off buffer between the read and write phases of a transfer.
// The valid flag marks that a read word is held and not yet written out.
module dma_word_buf
    import dma_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] data,
    output logic              valid
);

    // Capture the read word on load; drop valid once the write is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= din;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dma_xfer_engine.sv
// Single-channel memory-to-memory DMA initiator for the openMSP430 DMA master
// port. Each word is read from src, parked in a one-word buffer and written to
// dst; addresses advance by one word and wrap silently.
module dma_xfer_engine
    import dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    input  logic              prio,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              dma_en,
    output logic [ADDR_W-1:0] dma_addr,
    output logic [1:0]        dma_we,
    output logic [DATA_W-1:0] dma_din,
    output logic              dma_priority,
    output logic              dma_wkup,
    input  logic              dma_ready,
    input  logic              dma_resp,
    input  logic [DATA_W-1:0] dma_dout
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rd_err_q;

    logic              buf_load;
    logic              buf_clear;
    logic [DATA_W-1:0] buf_data;
    logic              buf_valid;

    // The read word arrives the cycle after the read is accepted (RD_WAIT);
    // it is released once the write that carries it has been accepted.
    assign buf_load  = (state == S_RD_WAIT);
    assign buf_clear = (state == S_WR_REQ) && dma_ready;

    dma_word_buf #(
        .DATA_W (DATA_W)
    ) u_word_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load),
        .clear (buf_clear),
        .din   (dma_dout),
        .data  (buf_data),
        .valid (buf_valid)
    );

    // Write data only carries a word while one is held for writing
    assign dma_din      = buf_valid ? buf_data : '0;
    assign dma_wkup     = busy;
    assign dma_priority = prio & busy;

    // Transfer sequencer; all request outputs are registered alongside the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            rd_err_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            dma_en   <= 1'b0;
            dma_addr <= '0;
            dma_we   <= DMA_WE_READ;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (word_cnt != '0) begin
                            src_q    <= src_addr;
                            dst_q    <= dst_addr;
                            cnt_q    <= word_cnt;
                            busy     <= 1'b1;
                            dma_en   <= 1'b1;
                            dma_we   <= DMA_WE_READ;
                            dma_addr <= src_addr;
                            state    <= S_RD_REQ;
                        end else begin
                            // Empty transfer: report completion without any access
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end

                S_RD_REQ: begin
                    if (dma_ready) begin
                        rd_err_q <= dma_resp;
                        dma_en   <= 1'b0;
                        state    <= S_RD_WAIT;
                    end
                end

                S_RD_WAIT: begin
                    if (rd_err_q) begin
                        busy  <= 1'b0;
                        error <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        dma_en   <= 1'b1;
                        dma_we   <= DMA_WE_WRITE;
                        dma_addr <= dst_q;
                        state    <= S_WR_REQ;
                    end
                end

                S_WR_REQ: begin
                    if (dma_ready) begin
                        dma_en <= 1'b0;
                        dma_we <= DMA_WE_READ;
                        if (dma_resp) begin
                            busy  <= 1'b0;
                            error <= 1'b1;
                            state <= S_ERR;
                        end else begin
                            src_q <= src_q + ADDR_ONE;
                            dst_q <= dst_q + ADDR_ONE;
                            cnt_q <= cnt_q - CNT_ONE;
                            if (cnt_q == CNT_ONE) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                // Next read follows immediately, no idle cycle
                                dma_en   <= 1'b1;
                                dma_addr <= src_q + ADDR_ONE;
                                state    <= S_RD_REQ;
                            end
                        end
                    end
                end

                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Bench for dma_xfer_engine: a memory slave with configurable wait states and
// error injection, plus a word-by-word copy model of the expected accesses.
module tb_dma_xfer_engine;

    typedef struct packed {
        logic [1:0]  we;
        logic [14:0] addr;
        logic [15:0] data;
    } acc_t;

    typedef struct {
        logic [14:0] src;
        logic [14:0] dst;
        logic [15:0] cnt;
        int          waits;
        int          err_at;
        bit          busy_start;
        bit          use_model;
        bit          exp_done;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [14:0] src_addr = '0;
    logic [14:0] dst_addr = '0;
    logic [15:0] word_cnt = '0;
    logic        prio = 1'b0;
    logic        dma_ready = 1'b0;
    logic        dma_resp = 1'b0;
    logic [15:0] dma_dout = '0;

    logic        busy, done, error, dma_en, dma_priority, dma_wkup;
    logic [14:0] dma_addr;
    logic [1:0]  dma_we;
    logic [15:0] dma_din;

    dma_xfer_engine dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .word_cnt     (word_cnt),
        .prio         (prio),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .dma_en       (dma_en),
        .dma_addr     (dma_addr),
        .dma_we       (dma_we),
        .dma_din      (dma_din),
        .dma_priority (dma_priority),
        .dma_wkup     (dma_wkup),
        .dma_ready    (dma_ready),
        .dma_resp     (dma_resp),
        .dma_dout     (dma_dout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Memory contents seen by the slave and by the reference model
    logic [15:0] mem       [0:32767];
    logic [15:0] model_mem [0:32767];

    acc_t acc_q[$];
    acc_t exp_q[$];

    int          waits_cfg = 0;
    int          err_at = -1;
    int          acc_n = 0;
    int          wcnt = 0;
    bit          rd_pending = 1'b0;
    logic [14:0] rd_addr = '0;
    logic [14:0] h_addr = '0;
    logic [1:0]  h_we = '0;
    logic [15:0] h_din = '0;

    // Memory slave: decides ready/resp for the current cycle on the falling
    // edge, logs accepted accesses and returns read data one cycle later.
    always @(negedge clk) begin
        dma_dout = rd_pending ? mem[rd_addr] : 16'($urandom);
        rd_pending = 1'b0;
        if (!rst) begin
            dma_ready = 1'b0;
            dma_resp  = 1'b0;
            wcnt      = 0;
        end else if (dma_en) begin
            if (wcnt == 0) begin
                h_addr = dma_addr;
                h_we   = dma_we;
                h_din  = dma_din;
            end else begin
                chk("hold_addr", 32'(dma_addr), 32'(h_addr));
                chk("hold_we", 32'(dma_we), 32'(h_we));
                if (h_we == 2'b11) chk("hold_din", 32'(dma_din), 32'(h_din));
            end
            if (wcnt >= waits_cfg) begin
                dma_ready = 1'b1;
                dma_resp  = (acc_n == err_at);
                acc_q.push_back({dma_we, dma_addr, dma_din});
                if (dma_we == 2'b00) begin
                    rd_pending = 1'b1;
                    rd_addr    = dma_addr;
                end else if (!dma_resp) begin
                    mem[dma_addr] = dma_din;
                end
                acc_n++;
                wcnt = 0;
            end else begin
                dma_ready = 1'b0;
                dma_resp  = 1'($urandom);
                wcnt++;
            end
        end else begin
            dma_ready = 1'($urandom);
            dma_resp  = 1'($urandom);
            wcnt      = 0;
        end
    end

    // Reference: the copy is an ordered list of read(src+i), write(dst+i, word),
    // truncated at the access that receives an error response.
    task automatic build_expect(input vec_t v, output int n_reads, output bit hit_err);
        logic [14:0] a;
        logic [14:0] d;
        logic [15:0] w;
        acc_t        e;
        a = v.src;
        d = v.dst;
        exp_q.delete();
        n_reads = 0;
        hit_err = 1'b0;
        for (int i = 0; i < int'(v.cnt) && !hit_err; i++) begin
            e.we = 2'b00; e.addr = a; e.data = 16'h0;
            exp_q.push_back(e);
            n_reads++;
            if (exp_q.size() - 1 == v.err_at) begin
                hit_err = 1'b1;
            end else begin
                w = model_mem[a];
                e.we = 2'b11; e.addr = d; e.data = w;
                exp_q.push_back(e);
                if (exp_q.size() - 1 == v.err_at) begin
                    hit_err = 1'b1;
                end else begin
                    model_mem[d] = w;
                    a = a + 15'd1;
                    d = d + 15'd1;
                end
            end
        end
    endtask

    task automatic run_xfer(input vec_t v, input string tag);
        int n_reads;
        bit hit;
        int cyc;
        bit fin;
        bit e_done;
        bit e_err;
        int e_lat;
        build_expect(v, n_reads, hit);
        if (v.use_model) begin
            e_done = !hit;
            e_err  = hit;
            e_lat  = 1 + exp_q.size() * (1 + v.waits) + n_reads;
        end else begin
            e_done = v.exp_done;
            e_err  = v.exp_err;
            e_lat  = v.exp_lat;
        end
        @(negedge clk);
        acc_q.delete();
        acc_n     = 0;
        waits_cfg = v.waits;
        err_at    = v.err_at;
        src_addr  = v.src;
        dst_addr  = v.dst;
        word_cnt  = v.cnt;
        prio      = 1'($urandom);
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        src_addr = 15'($urandom);
        dst_addr = 15'($urandom);
        word_cnt = 16'($urandom);
        cyc = 1;
        fin = 1'b0;
        while (cyc < 1000 && !fin) begin
            if (done || error) begin
                fin = 1'b1;
            end else begin
                chk({tag, "_busy"}, 32'(busy), 32'd1);
                chk({tag, "_wkup"}, 32'(dma_wkup), 32'd1);
                chk({tag, "_prio"}, 32'(dma_priority), 32'(prio));
                start = v.busy_start && (cyc == 3);
                if (start) word_cnt = 16'd7;
                prio = 1'($urandom);
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk({tag, "_finished"}, 32'(fin), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'(e_done));
        chk({tag, "_error"}, 32'(error), 32'(e_err));
        chk({tag, "_latency"}, 32'(cyc), 32'(e_lat));
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_n_acc"}, 32'(acc_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_acc%0d_addr", tag, i), 32'(acc_q[i].addr), 32'(exp_q[i].addr));
            chk($sformatf("%s_acc%0d_we", tag, i), 32'(acc_q[i].we), 32'(exp_q[i].we));
            if (exp_q[i].we == 2'b11)
                chk($sformatf("%s_acc%0d_din", tag, i), 32'(acc_q[i].data), 32'(exp_q[i].data));
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk({tag, "_quiet"}, 32'({dma_en, done, error, busy}), 32'd0);
        end
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i]       = 16'($urandom);
            model_mem[i] = mem[i];
        end
        mem[15'h0100]       = 16'hBEEF;
        model_mem[15'h0100] = 16'hBEEF;

        //            src       dst       cnt   w  err bs mdl done err lat
        tbl[0] = '{15'h0100, 15'h0200, 16'd1, 0, -1, 0, 0, 1, 0, 4};
        tbl[1] = '{15'h0010, 15'h0020, 16'd4, 2, -1, 0, 0, 1, 0, 29};
        tbl[2] = '{15'h0040, 15'h0050, 16'd3, 0,  3, 0, 0, 0, 1, 7};
        tbl[3] = '{15'h0300, 15'h0400, 16'd0, 0, -1, 0, 0, 1, 0, 1};
        tbl[4] = '{15'h7FFF, 15'h0500, 16'd2, 0, -1, 0, 0, 1, 0, 7};
        tbl[5] = '{15'h0600, 15'h0700, 16'd2, 1, -1, 1, 0, 1, 0, 11};
        tbl[6] = '{15'h0800, 15'h0900, 16'd2, 1,  2, 0, 0, 0, 1, 9};

        // Reset held with random inputs
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start    = 1'($urandom);
            src_addr = 15'($urandom);
            dst_addr = 15'($urandom);
            word_cnt = 16'($urandom);
            prio     = 1'($urandom);
            #1;
            chk("rst_dma_en", 32'(dma_en), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done_error", 32'({done, error}), 32'd0);
            chk("rst_dma_we", 32'(dma_we), 32'd0);
            chk("rst_dma_addr", 32'(dma_addr), 32'd0);
            chk("rst_dma_din", 32'(dma_din), 32'd0);
            chk("rst_wkup_prio", 32'({dma_wkup, dma_priority}), 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'({dma_en, busy, done, error}), 32'd0);
        end

        for (int i = 0; i < 7; i++) begin
            run_xfer(tbl[i], $sformatf("v%0d", i));
            if (i == 0) chk("v0_mem_0200", 32'(mem[15'h0200]), 32'hBEEF);
        end

        // Randomized transfers against the copy model
        for (int i = 0; i < 10; i++) begin
            rv.src        = 15'($urandom);
            rv.dst        = 15'($urandom);
            rv.cnt        = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
            rv.waits      = int'($urandom_range(0, 2));
            rv.err_at     = (rv.cnt != 0 && $urandom_range(0, 2) == 0)
                            ? int'($urandom_range(0, 2 * int'(rv.cnt) - 1)) : -1;
            rv.busy_start = 1'($urandom);
            rv.use_model  = 1'b1;
            rv.exp_done   = 1'b0;
            rv.exp_err    = 1'b0;
            rv.exp_lat    = 0;
            run_xfer(rv, $sformatf("r%0d", i));
        end

        // Reset in the middle of a burst, while a write is being requested
        @(negedge clk);
        acc_q.delete();
        acc_n     = 0;
        waits_cfg = 2;
        err_at    = -1;
        src_addr  = 15'h1000;
        dst_addr  = 15'h2000;
        word_cnt  = 16'd4;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && !(dma_en && dma_we == 2'b11); i++) @(negedge clk);
        chk("mid_rst_in_write", 32'({dma_en, dma_we}), 32'h7);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_dma_en", 32'(dma_en), 32'd0);
        chk("mid_rst_busy_wkup", 32'({busy, dma_wkup}), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_no_pulse", 32'({done, error, dma_en}), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32768; i++) model_mem[i] = mem[i];
        rv = '{15'h1000, 15'h2000, 16'd3, 1, -1, 0, 1, 0, 0, 0};
        run_xfer(rv, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_xfer_engine.md
Name: dma_xfer_engine

Overview:
Single-channel memory-to-memory DMA initiator driving the openMSP430 DMA master port (dma_en/dma_addr/dma_we/dma_din, with dma_ready/dma_resp/dma_dout returned). For each transfer it reads one 16-bit word from the source address, holds it in a one-word buffer, then writes it to the destination address, repeating for a programmed word count. It is the requesting end of the openMSP430 DMA write protocol and sits between the controller's channel registers and the CPU's DMA port.

Parameters:
ADDR_W, 15, word address width (dma_addr[15:1] of openMSP430)
CNT_W, 16, transfer word-count width
DATA_W, 16, data word width

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; launches a transfer when idle
src_addr  input  ADDR_W  first source word address (sampled on start)
dst_addr  input  ADDR_W  first destination word address (sampled on start)
word_cnt  input  CNT_W  number of words to move (sampled on start)
prio  input  1  passed to dma_priority while busy
busy  output  1  high from the cycle after accepted start until done/error
done  output  1  one-cycle pulse on successful completion
error  output  1  one-cycle pulse when dma_resp=1 ends the transfer
dma_en  output  1  DMA access request
dma_addr  output  ADDR_W  DMA word address
dma_we  output  2  byte write enables: 2'b11 for write, 2'b00 for read
dma_din  output  DATA_W  write data
dma_priority  output  1  DMA priority
dma_wkup  output  1  wakeup request
dma_ready  input  1  access accepted this cycle
dma_resp  input  1  error response for the accepted access
dma_dout  input  DATA_W  read data, valid the cycle after the read is accepted

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, error, dma_en, dma_wkup, and dma_priority are 0; dma_we=0; dma_addr, dma_din, the counter, and the buffer are 0.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE, ERR.
- IDLE: on start=1 with word_cnt!=0, latch the addresses and count, then go to RD_REQ. When word_cnt=0, pulse done on the next cycle (via DONE) and issue no DMA access. start is ignored when not IDLE.
- RD_REQ: drive dma_en=1, dma_we=00, dma_addr=src. Hold these until dma_ready=1, then go to RD_WAIT.
- RD_WAIT: capture dma_dout into the buffer. If dma_resp was 1 on the ready cycle, go to ERR. Otherwise go to WR_REQ.
- WR_REQ: drive dma_en=1, dma_we=11, dma_addr=dst, dma_din=buffer. Hold until dma_ready=1.
  - On ready with dma_resp=1: go to ERR.
  - On ready with resp=0: increment src and dst by 1 (modulo 2^ADDR_W, wrapping silently) and decrement the count. If the count reaches 0, go to DONE; else go to RD_REQ. There is no idle cycle between words.
- DONE: assert done for 1 cycle, then go to IDLE. ERR: assert error for 1 cycle, then go to IDLE. busy is 0 in both.
- dma_en is never asserted outside RD_REQ/WR_REQ. Address, we, and din are stable for every cycle dma_en=1 until ready.
- dma_wkup=busy, so a sleeping CPU clock is re-enabled. dma_priority=prio&busy.
- Latency per word with zero wait states: 3 cycles (RD_REQ, RD_WAIT, WR_REQ). N words take 3N cycles plus 1 DONE cycle.
- dma_resp is sampled only on cycles where dma_en&dma_ready=1.
- Reset mid-transfer: dma_en drops immediately (asynchronously), with no completion or error pulse. The half-moved word is lost.

Decomposition:
- Shared package dma_pkg: state encodings (IDLE..ERR), DMA_WE_READ=2'b00, DMA_WE_WRITE=2'b11, and default widths.
- One sub-module, dma_word_buf. It is a DATA_W holding register with a load enable and a valid flag, set on the read capture and cleared on the write accept. The engine instantiates it for the read-to-write hand-off.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0; release, stay IDLE with dma_en=0.
- Single word, zero wait: src=0x0100, dst=0x0200, cnt=1, dma_ready tied 1, memory[0x0100]=0xBEEF -> read at 0x0100, write 0xBEEF with we=11 at 0x0200, done pulse 4 cycles after start, busy high 3 cycles.
- Burst with wait states: cnt=4, src=0x0010, dst=0x0020, dma_ready low for 2 cycles on every access -> words 0x0010..0x0013 copied to 0x0020..0x0023 in order. Address, we, and din stay stable during the waits. Exactly 8 accepted accesses occur.
- Error on write: cnt=3, dma_resp=1 on the second write -> error pulses once, done never asserts, and no further dma_en.
- Edge cases: cnt=0 -> done pulses with no dma_en. src=0x7FFF, cnt=2 -> second read address wraps to 0x0000. A start pulse while busy is ignored, leaving the count unchanged.
- Reset mid-burst: rst low during WR_REQ -> dma_en=0 the same cycle, no done/error pulse; a new start after release runs normally.
